// File: rtl/can_pkg.sv
// Shared types and constants for the CAN bit destuffer.
package can_pkg;

   typedef enum logic [2:0] {IDLE, COUNT, EXPECT_STUFF, FIXED, ERROR} destuff_state_t;

   localparam logic CAN_RECESSIVE = 1'b1;
   localparam int   DEF_RUN_LEN   = 5;
   localparam int   DEF_FIXED_LEN = 4;

endpackage

// File: rtl/can_bit_destuffer.sv
// Removes dynamic and FD fixed stuff bits from the sampled CAN RX stream, flags stuff
// errors and counts dynamic stuff bits modulo 8.
module can_bit_destuffer
   import can_pkg::*;
#(
   parameter int RUN_LEN   = DEF_RUN_LEN,
   parameter int FIXED_LEN = DEF_FIXED_LEN,
   parameter bit FIXED_EN  = 1'b1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           sample_point,
   input  logic           rx_bit,
   input  logic           frame_start,
   input  logic           stuff_en,
   input  logic           fixed_mode,
   output logic           bit_out,
   output logic           bit_valid,
   output logic           stuff_bit,
   output logic           stuff_error,
   output logic           error_flag,
   output logic [2:0]     stuff_cnt,
   output destuff_state_t state_dbg
);

   localparam logic [3:0] RUN_LEN_W   = 4'(RUN_LEN);
   localparam logic [3:0] FIXED_LEN_W = 4'(FIXED_LEN);

   destuff_state_t state;
   destuff_state_t eff_state;
   logic [3:0]     run_cnt;
   logic [3:0]     fix_cnt;
   logic           prev_bit;
   logic [3:0]     base_run;
   logic [3:0]     base_fix;
   logic [2:0]     base_cnt;
   logic           base_prev;
   logic [3:0]     next_run;

   assign state_dbg = state;

   // frame_start re-initialises the context first, so a coincident strobe sees a fresh SOF.
   always_comb begin
      base_prev = frame_start ? CAN_RECESSIVE : prev_bit;
      base_run  = frame_start ? 4'd0 : run_cnt;
      base_fix  = frame_start ? 4'd0 : fix_cnt;
      base_cnt  = frame_start ? 3'd0 : stuff_cnt;
      eff_state = frame_start ? IDLE : state;
      if (eff_state != ERROR && !stuff_en) begin
         eff_state = IDLE;
      end else if (stuff_en && FIXED_EN && fixed_mode &&
                   (eff_state == COUNT || eff_state == EXPECT_STUFF)) begin
         // The strobe that switches to fixed stuffing carries the first fixed stuff bit.
         eff_state = FIXED;
         base_fix  = 4'd0;
      end else if (eff_state == FIXED && !(FIXED_EN && fixed_mode)) begin
         eff_state = COUNT;
      end
      next_run = (rx_bit == base_prev) ? base_run + 4'd1 : 4'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         run_cnt     <= 4'd1;
         fix_cnt     <= 4'd1;
         prev_bit    <= CAN_RECESSIVE;
         stuff_cnt   <= 3'd0;
         error_flag  <= 1'b0;
         bit_out     <= CAN_RECESSIVE;
         bit_valid   <= 1'b0;
         stuff_bit   <= 1'b0;
         stuff_error <= 1'b0;
      end else begin
         bit_valid   <= 1'b0;
         stuff_bit   <= 1'b0;
         stuff_error <= 1'b0;
         if (frame_start) begin
            state      <= IDLE;
            run_cnt    <= 4'd0;
            fix_cnt    <= 4'd0;
            prev_bit   <= CAN_RECESSIVE;
            stuff_cnt  <= 3'd0;
            error_flag <= 1'b0;
         end
         if (sample_point) begin
            case (eff_state)
               IDLE: begin
                  bit_out   <= rx_bit;
                  bit_valid <= 1'b1;
                  if (stuff_en) begin
                     prev_bit <= rx_bit;
                     run_cnt  <= 4'd1;
                     state    <= COUNT;
                  end else begin
                     state    <= IDLE;
                  end
               end
               COUNT: begin
                  bit_out   <= rx_bit;
                  bit_valid <= 1'b1;
                  prev_bit  <= rx_bit;
                  run_cnt   <= next_run;
                  state     <= (next_run == RUN_LEN_W) ? EXPECT_STUFF : COUNT;
               end
               EXPECT_STUFF: begin
                  if (rx_bit != base_prev) begin
                     stuff_bit <= 1'b1;
                     stuff_cnt <= base_cnt + 3'd1;
                     prev_bit  <= rx_bit;
                     run_cnt   <= 4'd1;
                     state     <= COUNT;
                  end else begin
                     stuff_error <= 1'b1;
                     error_flag  <= 1'b1;
                     state       <= ERROR;
                  end
               end
               FIXED: begin
                  run_cnt <= 4'd1;
                  if (base_fix == 4'd0) begin
                     if (rx_bit != base_prev) begin
                        stuff_bit <= 1'b1;
                        prev_bit  <= rx_bit;
                        fix_cnt   <= 4'd1;
                        state     <= FIXED;
                     end else begin
                        stuff_error <= 1'b1;
                        error_flag  <= 1'b1;
                        state       <= ERROR;
                     end
                  end else begin
                     // fix_cnt 1..FIXED_LEN numbers the data bits; 0 marks the stuff slot.
                     bit_out   <= rx_bit;
                     bit_valid <= 1'b1;
                     prev_bit  <= rx_bit;
                     fix_cnt   <= (base_fix == FIXED_LEN_W) ? 4'd0 : base_fix + 4'd1;
                     state     <= FIXED;
                  end
               end
               default: state <= ERROR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Randomised and directed bench for can_bit_destuffer against a queue-based stuffing model.
module tb_can_bit_destuffer;
   import can_pkg::*;

   localparam int RUN_LEN   = 5;
   localparam int FIXED_LEN = 4;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           sample_point = 1'b0;
   logic           rx_bit = 1'b1;
   logic           frame_start = 1'b0;
   logic           stuff_en = 1'b0;
   logic           fixed_mode = 1'b0;
   logic           bit_out, bit_valid, stuff_bit, stuff_error, error_flag;
   logic [2:0]     stuff_cnt;
   destuff_state_t state_dbg;

   int total = 0;
   int bad = 0;

   // Scoreboard vector: {bit_out, bit_valid, stuff_bit, stuff_error, error_flag, stuff_cnt}
   logic [7:0] exp_q[$];
   logic [7:0] got, exp;
   wire  [7:0] out_vec = {bit_out, bit_valid, stuff_bit, stuff_error, error_flag, stuff_cnt};

   // Reference model state: bits since the last dynamic stuff boundary, plus frame context.
   logic m_hist[$];
   logic m_out, m_err, m_region, m_fixed, m_last;
   int   m_cnt, m_fix_data;

   can_bit_destuffer #(.RUN_LEN(RUN_LEN), .FIXED_LEN(FIXED_LEN), .FIXED_EN(1'b1)) dut (
      .clock(clock), .reset(reset), .sample_point(sample_point), .rx_bit(rx_bit),
      .frame_start(frame_start), .stuff_en(stuff_en), .fixed_mode(fixed_mode),
      .bit_out(bit_out), .bit_valid(bit_valid), .stuff_bit(stuff_bit),
      .stuff_error(stuff_error), .error_flag(error_flag), .stuff_cnt(stuff_cnt),
      .state_dbg(state_dbg)
   );

   always #5 clock = ~clock;

   function automatic int trailing_run();
      int n = 0;
      if (m_hist.size() == 0) return 0;
      for (int i = m_hist.size() - 1; i >= 0; i--) begin
         if (m_hist[i] == m_hist[m_hist.size() - 1]) n++;
         else break;
      end
      return n;
   endfunction

   function automatic void model_reset();
      m_out = 1'b1; m_err = 1'b0; m_region = 1'b0; m_fixed = 1'b0; m_last = 1'b1;
      m_cnt = 0; m_fix_data = -1;
      m_hist.delete();
      exp_q.delete();
   endfunction

   function automatic void model_step(input logic rx, input logic fs, input logic en,
                                      input logic fm);
      logic v = 1'b0, s = 1'b0, e = 1'b0;
      if (fs) begin
         m_err = 1'b0; m_cnt = 0; m_region = 1'b0; m_fixed = 1'b0; m_last = 1'b1;
         m_hist.delete();
      end
      if (!m_err) begin
         if (!en) begin
            v = 1'b1; m_out = rx; m_region = 1'b0; m_fixed = 1'b0;
         end else if (!m_region) begin
            v = 1'b1; m_out = rx; m_region = 1'b1;
            m_hist.delete(); m_hist.push_back(rx);
         end else begin
            if (fm && !m_fixed) begin
               m_fixed = 1'b1; m_fix_data = -1;
            end else if (!fm && m_fixed) begin
               m_fixed = 1'b0; m_hist.delete(); m_hist.push_back(m_last);
            end
            if (m_fixed) begin
               if (m_fix_data < 0) begin
                  if (rx != m_last) begin s = 1'b1; m_fix_data = 0; end
                  else begin e = 1'b1; m_err = 1'b1; end
               end else begin
                  v = 1'b1; m_out = rx; m_fix_data++;
                  if (m_fix_data == FIXED_LEN) m_fix_data = -1;
               end
            end else if (trailing_run() == RUN_LEN) begin
               if (rx != m_last) begin
                  s = 1'b1; m_cnt = (m_cnt + 1) % 8;
                  m_hist.delete(); m_hist.push_back(rx);
               end else begin
                  e = 1'b1; m_err = 1'b1;
               end
            end else begin
               v = 1'b1; m_out = rx; m_hist.push_back(rx);
            end
         end
         m_last = rx;
      end
      exp_q.push_back({m_out, v, s, e, m_err, 3'(m_cnt)});
   endfunction

   task automatic send(input logic b, input logic fs, input logic en, input logic fm);
      rx_bit = b; frame_start = fs; stuff_en = en; fixed_mode = fm; sample_point = 1'b1;
      model_step(b, fs, en, fm);
      @(posedge clock); #1;
      sample_point = 1'b0; frame_start = 1'b0;
   endtask

   task automatic idle_cycle();
      rx_bit = 1'($urandom_range(0, 1));
      exp_q.push_back({m_out, 3'b000, m_err, 3'(m_cnt)});
      @(posedge clock); #1;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) @(posedge clock);
      #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rx_bit = 1'b0; stuff_en = 1'b1; sample_point = 1'b1;
      do_reset(2);
      sample_point = 1'b0;
      total++;
      if (out_vec !== 8'b1000_0000) begin
         bad++; $display("FAIL reset_outputs got=%b exp=%b", out_vec, 8'b1000_0000);
      end
      total++;
      if (state_dbg !== IDLE) begin
         bad++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE);
      end
   endtask

   task automatic test_basic_stuff();
      logic bits[7] = '{0, 0, 0, 0, 0, 1, 1};
      for (int i = 0; i < 7; i++) begin
         send(bits[i], i == 0, 1'b1, 1'b0);
         got = out_vec; exp = exp_q.pop_front(); total++;
         if (got !== exp) begin
            bad++; $display("FAIL basic_stuff[%0d] got=%b exp=%b", i, got, exp);
         end
      end
      total++;
      if (stuff_cnt !== 3'd1) begin
         bad++; $display("FAIL basic_stuff_cnt got=%0d exp=1", stuff_cnt);
      end
   endtask

   task automatic test_stuff_starts_run();
      logic bits[11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
      for (int i = 0; i < 11; i++) begin
         send(bits[i], i == 0, 1'b1, 1'b0);
         got = out_vec; exp = exp_q.pop_front(); total++;
         if (got !== exp) begin
            bad++; $display("FAIL stuff_run[%0d] got=%b exp=%b", i, got, exp);
         end
      end
      // The 0 stuff bit plus four 0 data bits form a full run, so the trailing 1 is stuff.
      total++;
      if (stuff_bit !== 1'b1 || stuff_cnt !== 3'd2) begin
         bad++; $display("FAIL stuff_run_second got=%b/%0d exp=1/2", stuff_bit, stuff_cnt);
      end
   endtask

   task automatic test_stuff_error();
      for (int i = 0; i < 9; i++) begin
         send(1'b0, i == 0, 1'b1, 1'b0);
         got = out_vec; exp = exp_q.pop_front(); total++;
         if (got !== exp) begin
            bad++; $display("FAIL stuff_error[%0d] got=%b exp=%b", i, got, exp);
         end
         if (i == 5) begin
            total++;
            if (stuff_error !== 1'b1 || error_flag !== 1'b1) begin
               bad++; $display("FAIL stuff_error_pulse got=%b%b exp=11", stuff_error, error_flag);
            end
         end
      end
      send(1'b1, 1'b1, 1'b0, 1'b0);
      got = out_vec; exp = exp_q.pop_front(); total++;
      if (got !== exp || error_flag !== 1'b0) begin
         bad++; $display("FAIL stuff_error_clear got=%b exp=%b", got, exp);
      end
   endtask

   task automatic test_fixed();
      logic d[4];
      logic fm;
      for (int i = 0; i < 4; i++) d[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 13; i++) begin
         logic b;
         fm = (i >= 2);
         if (i == 0) b = 1'b1;
         else if (i == 1) b = 1'b0;
         else if (i == 2) b = 1'b1;
         else if (i <= 6) b = d[i - 3];
         else if (i == 7) b = ~d[3];
         else if (i <= 11) b = d[i - 8];
         else b = d[3];
         send(b, i == 0, 1'b1, fm);
         got = out_vec; exp = exp_q.pop_front(); total++;
         if (got !== exp) begin
            bad++; $display("FAIL fixed[%0d] got=%b exp=%b", i, got, exp);
         end
      end
      total++;
      if (stuff_error !== 1'b1 || stuff_cnt !== 3'd0) begin
         bad++; $display("FAIL fixed_error got=%b/%0d exp=1/0", stuff_error, stuff_cnt);
      end
   endtask

   task automatic test_wrap_and_sof();
      logic b = 1'b0;
      int sent = 0;
      send(b, 1'b1, 1'b1, 1'b0);
      void'(exp_q.pop_front());
      while (m_cnt != 1 || sent < 20) begin
         if (trailing_run() == RUN_LEN) b = ~m_last;
         else b = m_last;
         send(b, 1'b0, 1'b1, 1'b0);
         sent++;
         got = out_vec; exp = exp_q.pop_front(); total++;
         if (got !== exp) begin
            bad++; $display("FAIL wrap[%0d] got=%b exp=%b", sent, got, exp);
         end
         if (sent > 80) break;
      end
      total++;
      if (stuff_cnt !== 3'd1) begin
         bad++; $display("FAIL wrap_count got=%0d exp=1", stuff_cnt);
      end
      send(1'b0, 1'b1, 1'b1, 1'b0);
      got = out_vec; exp = exp_q.pop_front(); total++;
      if (got !== exp || state_dbg !== COUNT) begin
         bad++; $display("FAIL sof_strobe got=%b/%0d exp=%b/%0d", got, state_dbg, exp, COUNT);
      end
   endtask

   task automatic test_passthrough();
      for (int i = 0; i < 12; i++) begin
         send(1'b0, 1'b0, 1'b0, 1'b0);
         got = out_vec; exp = exp_q.pop_front(); total++;
         if (got !== exp) begin
            bad++; $display("FAIL passthrough[%0d] got=%b exp=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 3; i++) send(1'b0, i == 0, 1'b1, 1'b0);
      do_reset(1);
      total++;
      if (out_vec !== 8'b1000_0000 || state_dbg !== IDLE) begin
         bad++; $display("FAIL mid_reset got=%b/%0d exp=%b/0", out_vec, state_dbg, 8'b1000_0000);
      end
   endtask

   task automatic test_random();
      logic en = 1'b1;
      for (int i = 0; i < 600; i++) begin
         logic b, fs;
         fs = (i == 0) || ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) en = ~en;
         if (en && m_region && !m_err && trailing_run() == RUN_LEN && $urandom_range(0, 9) != 0)
            b = ~m_last;
         else if ($urandom_range(0, 2) != 0) b = m_last;
         else b = 1'($urandom_range(0, 1));
         send(b, fs, en, 1'b0);
         got = out_vec; exp = exp_q.pop_front(); total++;
         if (got !== exp) begin
            bad++; $display("FAIL random[%0d] got=%b exp=%b", i, got, exp);
         end
         if ($urandom_range(0, 3) == 0) begin
            idle_cycle();
            got = out_vec; exp = exp_q.pop_front(); total++;
            if (got !== exp) begin
               bad++; $display("FAIL random_gap[%0d] got=%b exp=%b", i, got, exp);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_stuff();
      test_stuff_starts_run();
      test_stuff_error();
      test_fixed();
      test_wrap_and_sof();
      test_passthrough();
      test_reset_mid_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
